// File: rtl/seq_divider_if.sv
// Handshake and data bundle for the sequential restoring divider.
// The master issues start with operands; the slave returns results and status.
interface seq_divider_if #(
  parameter int DW = 16,
  parameter int VW = 8
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          busy;
  logic          done;
  logic          div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, DW iterations.
// Results are registered and held until the next completion.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | after reset, waiting for start
// S_RUN  | iterating; busy=1, cnt counts DW down to 0
// S_DONE | result valid (done=1); a new start restarts. With pend_q set,
//        | a zero divisor was just accepted and results publish next edge
module seq_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [DW-1:0] dq_q;
  logic [VW-1:0] dv_q;
  logic [VW-1:0] rem_q;
  logic [CW-1:0] cnt_q;
  logic          pend_q;
  logic [DW-1:0] quot_q;
  logic [VW-1:0] remo_q;
  logic          busy_q;
  logic          done_q;
  logic          dbz_q;

  logic [VW:0]   t_d;
  logic          ge_d;
  logic [VW-1:0] rem_d;
  logic [DW-1:0] dq_d;
  logic [CW-1:0] cnt_d;

  // One restoring step. The partial remainder is always < dv, so after a
  // successful subtract the result fits in VW bits; the wrap of the VW-bit
  // subtraction therefore yields the exact value.
  always_comb begin
    t_d   = {rem_q, dq_q[DW-1]};
    ge_d  = (t_d >= {1'b0, dv_q});
    rem_d = ge_d ? (t_d[VW-1:0] - dv_q) : t_d[VW-1:0];
    dq_d  = {dq_q[DW-2:0], ge_d};
    cnt_d = cnt_q - CW'(1);
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dq_q    <= '0;
      dv_q    <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (pend_q) begin
            // zero divisor accepted last edge: publish the fixed result
            pend_q <= 1'b0;
            quot_q <= '1;
            remo_q <= '0;
            dbz_q  <= 1'b1;
            done_q <= 1'b1;
          end else if (bus.start) begin
            dq_q   <= bus.dividend;
            dv_q   <= bus.divisor;
            rem_q  <= '0;
            cnt_q  <= CW'(DW);
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            if (bus.divisor != '0) begin
              busy_q  <= 1'b1;
              state_q <= S_RUN;
            end else begin
              pend_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_RUN: begin
          dq_q  <= dq_d;
          rem_q <= rem_d;
          cnt_q <= cnt_d;
          if (cnt_q == CW'(1)) begin
            quot_q  <= dq_d;
            remo_q  <= rem_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.quotient    = quot_q;
  assign bus.remainder   = remo_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results computed
// with plain division; a negedge monitor pops and compares on each done rise.
module tb_seq_divider;
  localparam int DW = 16;
  localparam int VW = 8;

  logic clk = 1'b0;
  logic rst;

  seq_divider_if #(.DW(DW), .VW(VW)) bus ();

  seq_divider #(.DW(DW), .VW(VW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [15:0] held_q   = '0;
  logic [7:0]  held_r   = '0;
  logic        done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b, input int acc);
    exp_t e;
    e.acc = acc;
    if (b == 8'd0) begin
      e.q = 16'hFFFF; e.r = 8'd0; e.dz = 1'b1; e.lat = 1;
    end else begin
      e.q = a / 16'(b); e.r = 8'(a % 16'(b)); e.dz = 1'b0; e.lat = 16;
    end
    return e;
  endfunction

  // Monitor: on every done rise, pop the oldest expectation and compare.
  always @(negedge clk) begin
    if (rst) begin
      done_prev <= 1'b0;
    end else begin
      if (bus.done && !done_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", 32'(bus.quotient), 32'(e.q));
          chk("remainder", 32'(bus.remainder), 32'(e.r));
          chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("busy_at_done", 32'(bus.busy), 32'd0);
          held_q = e.q;
          held_r = e.r;
        end
      end
      done_prev <= bus.done;
    end
  end

  // Called at a negedge; returns at the negedge where done is seen high.
  task automatic wait_done(input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) chk("timeout_done", 32'(bus.done), 32'd1);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [7:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    sb.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 8'($urandom);
    chk("busy_after_accept", 32'(bus.busy), 32'(b != 8'd0));
    chk("done_cleared", 32'(bus.done), 32'd0);
    chk("hold_quotient", 32'(bus.quotient), 32'(held_q));
    chk("hold_remainder", 32'(bus.remainder), 32'(held_r));
    wait_done(40);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_q"}, 32'(bus.quotient), 32'd0);
    chk({name, "_r"}, 32'(bus.remainder), 32'd0);
    chk({name, "_busy"}, 32'(bus.busy), 32'd0);
    chk({name, "_done"}, 32'(bus.done), 32'd0);
    chk({name, "_dbz"}, 32'(bus.div_by_zero), 32'd0);
  endtask

  initial begin
    logic [15:0] a16;
    logic [7:0]  b8;
    logic [15:0] p;

    rst = 1'b1;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // directed vectors
    do_op(16'd100, 8'd7);
    do_op(16'd65535, 8'd255);
    do_op(16'd65535, 8'd1);
    do_op(16'd5, 8'd9);
    do_op(16'd1234, 8'd0);
    do_op(16'd0, 8'd5);
    do_op(16'd65535, 8'd0);
    do_op(16'd255, 8'd255);

    // start while busy is ignored
    bus.start = 1'b1; bus.dividend = 16'd200; bus.divisor = 8'd3;
    sb.push_back(model(16'd200, 8'd3, cyc + 1));
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'd9; bus.divisor = 8'd4;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_ignore", 32'(bus.busy), 32'd1);
    wait_done(40);

    // reset mid-run aborts with no done pulse
    bus.start = 1'b1; bus.dividend = 16'd200; bus.divisor = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    sb.delete();
    held_q = '0; held_r = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_done_after_abort", 32'(bus.done), 32'd0);
    do_op(16'd9, 8'd4);

    // start held high: back-to-back runs, done high exactly one cycle between
    bus.start = 1'b1; bus.dividend = 16'd1000; bus.divisor = 8'd7;
    sb.push_back(model(16'd1000, 8'd7, cyc + 1));
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      wait_done(40);
      if (k < 2) begin
        sb.push_back(model(16'd1000, 8'd7, cyc + 1));
        @(negedge clk);
        chk("held_done_one_cycle", 32'(bus.done), 32'd0);
        chk("held_busy", 32'(bus.busy), 32'd1);
      end else begin
        bus.start = 1'b0;
      end
    end
    @(negedge clk);
    chk("stay_done", 32'(bus.done), 32'd1);

    // random operands, occasional zero divisor
    for (int i = 0; i < 200; i++) begin
      a16 = 16'($urandom);
      b8  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      do_op(a16, b8);
    end

    // round trip: divide a product by b to recover a
    for (int i = 0; i < 1000; i++) begin
      a16 = 16'($urandom_range(0, 255));
      b8  = 8'($urandom_range(1, 255));
      p   = a16 * 16'(b8);
      do_op(p, b8);
      chk("roundtrip_a", 32'(bus.quotient), 32'(a16));
      chk("roundtrip_r", 32'(bus.remainder), 32'd0);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
